// File: rtl/tri_sort_sched.sv
// tri_sort_sched
//
// Shared triangle vertex y-sort scheduler. Two requesters offer screen-space
// triangles; a round-robin arbiter picks one while idle, and a three-step
// compare-swap network (v1/v2, v2/v3, v1/v2) sorts the vertices by ascending
// signed y. The sort is stable: vertices with equal y keep their input order.
//
// Handshake rule (all three channels): a transfer happens on a rising clk edge
// where valid && ready are both high. A source holds valid and its data stable
// until that edge. Ready never depends on the data, only on valids and state.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req0_valid/ready   requester 0 handshake
//   req0_tri [6W]      requester 0 triangle {v3y,v3x,v2y,v2x,v1y,v1x}
//   req1_*             requester 1, same as requester 0
//   out_valid/ready    sorted-triangle handshake to edge setup
//   out_tri [6W]       sorted triangle, same packing, v1y <= v2y <= v3y
//   out_src            requester index that supplied out_tri
//   out_flat           sorted v1y == v3y (zero-height triangle)
//   busy               block is not idle
module tri_sort_sched #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [6*W-1:0] req0_tri,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [6*W-1:0] req1_tri,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [6*W-1:0] out_tri,
    output logic           out_src,
    output logic           out_flat,
    output logic           busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Vertex registers, index 0..2 = v1..v3.
    logic signed [W-1:0] vx [3];
    logic signed [W-1:0] vy [3];

    logic src;
    logic last_grant;
    logic flat;

    logic any_valid;
    logic grant;
    logic accept;
    logic [6*W-1:0] sel_tri;
    logic swap_01;
    logic swap_12;

    // Arbitration: a lone requester always wins; on contention the one that
    // did not win last time is chosen.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req0_valid) begin
            grant = 1'b0;
        end else begin
            grant = 1'b1;
        end
        accept  = (state == IDLE) && any_valid;
        sel_tri = grant ? req1_tri : req0_tri;
    end

    // Strict compares keep equal-y vertices in input order.
    always_comb begin
        swap_01 = vy[0] > vy[1];
        swap_12 = vy[1] > vy[2];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = S0;
            S0:      state_nxt = S1;
            S1:      state_nxt = S2;
            S2:      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. Readys are also forced low while reset is asserted, since the
    // state register alone would present IDLE during reset.
    always_comb begin
        req0_ready = rst_n && accept && !grant;
        req1_ready = rst_n && accept && grant;
        out_valid  = (state == DONE);
        busy       = (state != IDLE);
        out_tri    = {vy[2], vx[2], vy[1], vx[1], vy[0], vx[0]};
        out_src    = src;
        out_flat   = flat;
    end

    // Datapath: load on accept, one compare-swap per sort state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
            src        <= 1'b0;
            last_grant <= 1'b1;
            flat       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        vx[0]      <= sel_tri[0*W +: W];
                        vy[0]      <= sel_tri[1*W +: W];
                        vx[1]      <= sel_tri[2*W +: W];
                        vy[1]      <= sel_tri[3*W +: W];
                        vx[2]      <= sel_tri[4*W +: W];
                        vy[2]      <= sel_tri[5*W +: W];
                        src        <= grant;
                        last_grant <= grant;
                    end
                end
                S0, S2: begin
                    if (swap_01) begin
                        vx[0] <= vx[1];
                        vy[0] <= vy[1];
                        vx[1] <= vx[0];
                        vy[1] <= vy[0];
                    end
                    // After the final swap the smallest y sits in whichever
                    // of v1/v2 ends up first; v3 already holds the largest.
                    if (state == S2) begin
                        flat <= ((swap_01 ? vy[1] : vy[0]) == vy[2]);
                    end
                end
                S1: begin
                    if (swap_12) begin
                        vx[1] <= vx[2];
                        vy[1] <= vy[2];
                        vx[2] <= vx[1];
                        vy[2] <= vy[1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/tri_sort_sched.md
# tri_sort_sched

Shared triangle vertex y-sort scheduler for the rasterizer front end. Two transform-stage requesters submit screen-space triangles over valid/ready. The block arbitrates them round-robin and loads the winner into one iterative compare-swap sorter. It emits the triangle with its three vertices ordered by ascending signed y, tagged with its source, to the edge-setup stage.

## Interface
- W, default 16: coordinate width, signed two's complement.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a triangle.
- req0_ready  out  1  block accepts from requester 0 this cycle.
- req0_tri  in  6*W  packed triangle: [W-1:0]=v1x, [2W-1:W]=v1y, [3W-1:2W]=v2x, [4W-1:3W]=v2y, [5W-1:4W]=v3x, [6W-1:5W]=v3y.
- req1_valid, req1_ready, req1_tri: same as requester 0, for requester 1.
- out_valid  out  1  sorted triangle available.
- out_ready  in  1  downstream accepts.
- out_tri  out  6*W  sorted triangle, same packing; v1y <= v2y <= v3y.
- out_src  out  1  index of the requester that supplied out_tri.
- out_flat  out  1  1 when sorted v1y == v3y (zero-height triangle).
- busy  out  1  high whenever state != IDLE.

## Operation
- State machine: IDLE -> S0 -> S1 -> S2 -> DONE -> IDLE.
- IDLE:
  - reqN_ready = 1 only for the granted requester; grant is a combinational function of the valids and last_grant.
  - Only one requester valid: it is granted.
  - Both valid: the requester != last_grant is granted.
  - On the handshake edge: load that requester's tri into the vertex regs, record src, update last_grant := src, go to S0.
  - No requester valid: stay in IDLE; both readys 0.
- Outside IDLE: req0_ready = req1_ready = 0.
- S0: compare-swap (v1, v2). S1: compare-swap (v2, v3). S2: compare-swap (v1, v2), then go to DONE.
- Compare-swap (a, b):
  - Swap the whole (x, y) pairs iff signed a.y > signed b.y; strict compare, so equal y values keep input order (stable sort).
  - No arithmetic beyond the compare; widths unchanged.
- DONE:
  - out_valid = 1; out_tri, out_src and out_flat are driven from registers and held stable while out_ready = 0.
  - out_valid && out_ready at an edge completes the transfer; go to IDLE.
- A valid request present while not in IDLE waits; requesters must hold valid and data until ready.
- Reset (asserted at any time, including mid-sort or in DONE):
  - State goes to IDLE immediately and the in-flight triangle is discarded.
  - out_valid = 0, out_tri = 0, out_src = 0, out_flat = 0, busy = 0, req readys = 0 while rst_n is low.
  - last_grant = 1, so requester 0 wins the first contention.

## Timing
- Accept at edge E0. S0, S1 and S2 occupy the cycles after E0, E1 and E2 respectively. out_valid rises after E3 (3-cycle latency).
- With out_ready held high: transfer at E4, IDLE in the next cycle, next accept possible at E5. Peak throughput is 1 triangle per 5 cycles.
- out_ready low extends DONE indefinitely, with no change to the out_* signals.
- out_flat is registered at the S2 -> DONE edge.
- busy rises the cycle after E0 and falls the cycle after the output transfer.

## Test plan
- Single triangle, ordering: req0 only, tri y=(30,10,20), x=(1,2,3). Required: out_valid 3 cycles after accept; out y=(10,20,30), x=(2,3,1); out_src=0; out_flat=0.
- Round-robin arbitration: req0 and req1 both valid and held for 3 triangles each, out_ready=1. Required: grant order 0,1,0,1,0,1; accepts spaced 5 cycles apart; out_src matches the grant order.
- Backpressure: out_ready=0 for 6 cycles in DONE with req1_valid=1. Required: out_tri/out_src stable; req1_ready=0 throughout; req1 accepted the cycle after the out transfer completes.
- Signed values and ties: y=(-5,-5,-32768), x=(7,8,9). Required: out y=(-32768,-5,-5), x=(9,7,8) (stable order for the tie). Also y=(4,4,4): out_flat=1 and order unchanged.
- Reset mid-operation: assert rst_n=0 in S1, release after 2 cycles. Required: all outputs 0 during reset; no out_valid for the discarded triangle; with both requesters then valid, req0 is granted first.
